// File: rtl/sequential_binary_multiplier_if.sv
// Purpose: operand/result bundle for the sequential shift-and-add multiplier.
// Latency: none, wires only.
// Backpressure: Start is honoured only while Ready is high; there is no other flow control.
// Ports (signals): Multiplicand, Multiplier, Start driven by the requester (master);
//                  Product, Ready driven by the multiplier (slave).
interface sequential_binary_multiplier_if #(
  parameter int dp_width = 4
);
  logic [dp_width-1:0]   Multiplicand;
  logic [dp_width-1:0]   Multiplier;
  logic                  Start;
  logic [2*dp_width-1:0] Product;
  logic                  Ready;

  modport master (
    output Multiplicand, Multiplier, Start,
    input  Product, Ready
  );

  modport slave (
    input  Multiplicand, Multiplier, Start,
    output Product, Ready
  );
endinterface

// File: rtl/sequential_binary_multiplier.sv
// Purpose: unsigned shift-and-add multiplier producing a 2*dp_width-bit product.
// Latency: 2*dp_width+1 rising edges from the Start-sampling edge to Ready high.
// Backpressure: Start is ignored while busy (Ready low); a held Start restarts on the first idle cycle.
// Ports: clock        - rising-edge clock
//        reset_b      - asynchronous, active-high reset (returns to idle, clears all registers)
//        bus (slave)  - Multiplicand/Multiplier/Start in, Product = {A,Q} and Ready out
module sequential_binary_multiplier #(
  parameter int dp_width = 4
) (
  input  logic                          clock,
  input  logic                          reset_b,
  sequential_binary_multiplier_if.slave bus
);
  localparam int PW = $clog2(dp_width) + 1;

  typedef enum logic [1:0] {
    S_idle  = 2'd0,
    S_add   = 2'd1,
    S_shift = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [dp_width-1:0] A, A_d;
  logic [dp_width-1:0] B, B_d;
  logic [dp_width-1:0] Q, Q_d;
  logic                C, C_d;
  logic [PW-1:0]       P, P_d;

  // One extra bit so the carry out of A+B lands in C and the product stays exact.
  logic [dp_width:0]   sum;
  assign sum = {1'b0, A} + {1'b0, B};

  always_comb begin
    state_d = state_q;
    A_d     = A;
    B_d     = B;
    Q_d     = Q;
    C_d     = C;
    P_d     = P;
    case (state_q)
      S_idle: begin
        if (bus.Start) begin
          A_d     = '0;
          C_d     = 1'b0;
          P_d     = PW'(dp_width);
          B_d     = bus.Multiplicand;
          Q_d     = bus.Multiplier;
          state_d = S_add;
        end
      end
      S_add: begin
        P_d = P - PW'(1);
        if (Q[0]) begin
          {C_d, A_d} = sum;
        end
        state_d = S_shift;
      end
      S_shift: begin
        // {C,A,Q} >> 1: old C enters A's MSB, A[0] enters Q's MSB.
        C_d = 1'b0;
        A_d = {C, A[dp_width-1:1]};
        Q_d = {A[0], Q[dp_width-1:1]};
        // P was already decremented in the preceding add step.
        state_d = (P == '0) ? S_idle : S_add;
      end
      default: begin
        state_d = S_idle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset_b) begin
    if (reset_b) begin
      state_q <= S_idle;
      A       <= '0;
      B       <= '0;
      Q       <= '0;
      C       <= 1'b0;
      P       <= '0;
    end else begin
      state_q <= state_d;
      A       <= A_d;
      B       <= B_d;
      Q       <= Q_d;
      C       <= C_d;
      P       <= P_d;
    end
  end

  assign bus.Product = {A, Q};
  assign bus.Ready   = (state_q == S_idle);
endmodule

// File: tb/tb_sequential_binary_multiplier.sv
// Purpose: self-checking bench for sequential_binary_multiplier (dp_width = 4).
// Latency: n/a.
// Backpressure: n/a.
module tb_sequential_binary_multiplier;
  localparam int W = 4;

  logic clock;
  logic reset_b;
  int   n_checks;
  int   n_fail;

  sequential_binary_multiplier_if #(.dp_width(W)) bus ();

  sequential_binary_multiplier #(.dp_width(W)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // After k add/shift iterations the upper part of {A,Q} holds the partial product of
  // the k low multiplier bits, and the low W-k bits of Q still hold the unused multiplier bits.
  function automatic int exp_trace(input int a, input int b, input int k);
    return ((a * (b % (1 << k))) << (W - k)) | (b >> k);
  endfunction

  task automatic run_mul(input int a, input int b, input bit hold, input bit trace,
                         output bit saw_carry);
    int cycles;
    cycles    = 0;
    saw_carry = 1'b0;
    @(negedge clock);
    bus.Multiplicand = W'(a);
    bus.Multiplier   = W'(b);
    bus.Start        = 1'b1;
    @(posedge clock);
    #1;
    chk($sformatf("ready_fall_%0dx%0d", a, b), bus.Ready, 0);
    if (!hold) bus.Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if ((n % 2 == 1) && dut.C) saw_carry = 1'b1;
      if (trace && (n % 2 == 0) && (n <= 2 * W))
        chk($sformatf("trace_iter%0d", n / 2), {dut.C, dut.A, dut.Q}, exp_trace(a, b, n / 2));
      if (bus.Ready) begin
        cycles = n;
        break;
      end
    end
    chk($sformatf("latency_%0dx%0d", a, b), cycles, 2 * W);
    chk($sformatf("product_%0dx%0d", a, b), bus.Product, a * b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit sc;
    int ra, rb;
    n_checks         = 0;
    n_fail           = 0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    bus.Start        = 1'b0;
    reset_b          = 1'b1;

    // Reset state
    #12;
    chk("reset_ready", bus.Ready, 1);
    chk("reset_product", bus.Product, 0);
    chk("reset_regs", {dut.C, dut.B, dut.P}, 0);
    @(negedge clock);
    reset_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_hold_ready", bus.Ready, 1);
    chk("idle_hold_product", bus.Product, 0);

    // Reference trace 8 x 9 = 72, then the result must hold while idle
    run_mul(8, 9, 1'b0, 1'b1, sc);
    repeat (3) @(posedge clock);
    #1;
    chk("product_hold", bus.Product, 72);
    chk("ready_hold", bus.Ready, 1);

    // Carry path
    run_mul(15, 15, 1'b0, 1'b1, sc);
    chk("carry_seen", sc, 1);

    // Zero operands
    run_mul(0, 11, 1'b0, 1'b0, sc);
    run_mul(11, 0, 1'b0, 1'b0, sc);

    // Start held high for the whole run, then an immediate restart
    run_mul(3, 5, 1'b1, 1'b0, sc);
    @(posedge clock);
    #1;
    chk("restart_busy", bus.Ready, 0);
    chk("restart_operands", {dut.B, dut.Q}, {4'd3, 4'd5});
    bus.Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.Ready) break;
    end
    chk("restart_ready", bus.Ready, 1);
    chk("restart_product", bus.Product, 15);

    // Reset in the add step of the third iteration
    @(negedge clock);
    bus.Multiplicand = 4'd15;
    bus.Multiplier   = 4'd15;
    bus.Start        = 1'b1;
    @(posedge clock);
    #1;
    bus.Start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("p_iter3", dut.P, 2);
    chk("busy_iter3", bus.Ready, 0);
    #1;
    reset_b = 1'b1;
    #1;
    chk("midreset_ready", bus.Ready, 1);
    chk("midreset_product", bus.Product, 0);
    chk("midreset_regs", {dut.C, dut.B, dut.P}, 0);
    @(negedge clock);
    reset_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("post_reset_idle", {bus.Ready, bus.Product}, {1'b1, 8'd0});
    run_mul(6, 7, 1'b0, 1'b1, sc);

    // Random operands
    for (int i = 0; i < 16; i++) begin
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      run_mul(ra, rb, 1'b0, (i % 4 == 0), sc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sequential_binary_multiplier.md
# sequential_binary_multiplier

Unsigned shift-and-add multiplier: one add/shift datapath iterated over the multiplier bits, with a Start/Ready handshake. It computes the 2×dp_width-bit product of two dp_width-bit operands in 2×dp_width clock cycles. It is a standalone arithmetic block; the parent asserts Start while the block is idle and reads Product once Ready returns high.

## Interface
- dp_width, default 4: operand width in bits; must be at least 2.
- clock  input  1  single clock; all state changes on the rising edge.
- reset_b  input  1  asynchronous, active-high reset. When it is 1, the block resets immediately, without waiting for a clock edge.
- Multiplicand  input  dp_width  unsigned operand; captured into register B on Start.
- Multiplier  input  dp_width  unsigned operand; captured into register Q on Start.
- Start  input  1  begin a multiplication; sampled only in S_idle.
- Product  output  2*dp_width  concatenation {A, Q}.
- Ready  output  1  high exactly when the state machine is in S_idle.

Internal registers must be named A, B, Q (each dp_width), C (1-bit carry) and P (iteration counter, $clog2(dp_width)+1 bits), so the bench can probe them hierarchically.

## Operation
- The state machine has three states: S_idle, S_add, S_shift.
- **Reset:** state goes to S_idle. A, B, Q, C and P are all cleared to 0, so Product = 0 and Ready = 1.
- **S_idle:** Ready = 1.
  - If Start = 1: A←0, C←0, P←dp_width, B←Multiplicand, Q←Multiplier, then go to S_add.
  - Otherwise all registers hold.
- **S_add:**
  - P←P−1.
  - If Q[0] = 1: {C,A}←A+B (unsigned, carry into C). Otherwise A and C hold.
  - Go to S_shift.
- **S_shift:**
  - {C,A,Q}←{C,A,Q}>>1 (logical shift right; C←0, the old C moves into A's MSB, A[0] moves into Q's MSB).
  - If P = 0, go to S_idle; otherwise go to S_add.
- **Arithmetic:** unsigned only. The carry is kept, so the full 2×dp_width result is exact. Maximum case 15×15 = 225 fits in 8 bits.
- **Start while busy** (S_add or S_shift) is ignored. A held-high Start restarts a new operation on the first S_idle cycle.
- **Product during operation** shows intermediate {A,Q} and is valid only when Ready = 1 after a completed run. It holds until the next accepted Start.
- **Reset mid-operation** aborts immediately to the reset state above; there is no partial result.

## Timing
- Cycle 0: rising edge in S_idle with Start = 1 loads the operands. Ready falls after this edge (Ready is decoded from state, not registered separately).
- The block then alternates S_add and S_shift dp_width times: 2×dp_width edges in total after the load edge.
- Ready returns high after the last S_shift edge, and Product is final at that point. Latency from the Start-sampling edge to Ready high is 2×dp_width + 1 edges (9 for dp_width = 4).
- A new Start may be accepted on the first edge where Ready = 1.
- The counter sequence for dp_width = 4 is P = 100, 011, 010, 001, 000. It decrements in S_add; the S_shift with P = 000 exits.

## Test plan
- **Reset:** reset_b = 1 asynchronously mid-cycle → Ready = 1 and Product = 0 immediately. After reset_b = 0, the block is idle and holds with Start = 0.
- **Reference trace:** Multiplicand = 1000, Multiplier = 1001, Start pulsed one cycle. After each S_shift, {C,A,Q} must be:
  - 0_0100_0100
  - 0_0010_0010
  - 0_0001_0001
  - 0_0100_1000

  Final Product = 01001000 (72); Ready stays low for exactly 8 cycles.
- **Carry path:** 1111 × 1111 → Product = 11100001 (225). C must be 1 after at least one S_add.
- **Zero operands:** 0000 × 1011 → 0; 1011 × 0000 → 0. Both take the full 8-cycle latency.
- **Start while busy:** Start held high for the whole run with 0011 × 0101. The result is 15 with no corruption, and a new run starts on the first Ready cycle.
- **Reset mid-operation:** assert reset_b in S_add of the third iteration → immediate return to idle with Product = 0. A subsequent run of 0110 × 0111 gives 42.
